// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Sequencer and arbiter for the single-port 16Kx16 screen SPRAM.
//   After reset it copies DEPTH words from the ROM reader into SPRAM
//   (LOAD). It then shares the single SPRAM port between the display
//   scan-out reader and the CPU screen port (RUN). The display has
//   priority. The CPU is guaranteed a slot after at most CPU_STARVE
//   consecutive display wins.
//
// Ports
//   clk, reset                    : single clock, synchronous active-high reset
//   load_valid/load_data/load_ready : ROM word stream, accepted one per cycle in LOAD
//   loaded                        : high once every ROM word is in SPRAM
//   disp_req/disp_addr            : display read request (held until granted)
//   disp_gnt/disp_rvalid/disp_rdata : display grant, read data one cycle later
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : CPU request (held until granted)
//   cpu_gnt/cpu_rvalid/cpu_rdata  : CPU grant, read data one cycle later
//   ram_addr/ram_wren/ram_din     : drive the SPRAM port
//   ram_dout                      : SPRAM registered read data
module vram_arbiter #(
  parameter int DEPTH      = 16384,
  parameter int CPU_STARVE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic        loaded,
  input  logic        disp_req,
  input  logic [13:0] disp_addr,
  output logic        disp_gnt,
  output logic        disp_rvalid,
  output logic [15:0] disp_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  output logic [13:0] ram_addr,
  output logic        ram_wren,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout
);

  localparam int WADDR_W  = $clog2(DEPTH) + 1;
  localparam int STARVE_W = $clog2(CPU_STARVE + 1);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [WADDR_W-1:0]  waddr;
  logic [STARVE_W-1:0] starve;
  logic                disp_vld_p1;
  logic                cpu_vld_p1;
  logic                load_fire;
  logic                cpu_blocks_disp;

  // The CPU takes the slot from a requesting display only after the
  // display has already won CPU_STARVE cycles in a row against it.
  assign cpu_blocks_disp = cpu_req && (starve == STARVE_W'(CPU_STARVE));
  assign load_fire       = load_ready && load_valid;

  // Stage p0: grant decision and SPRAM port drive
  always_comb begin
    load_ready = 1'b0;
    disp_gnt   = 1'b0;
    cpu_gnt    = 1'b0;
    ram_addr   = disp_addr;
    ram_wren   = 1'b0;
    ram_din    = 16'h0000;
    // Nothing touches the SPRAM port while reset is held, whatever the
    // current phase, so a reset can never corrupt memory.
    if (!reset) begin
      if (state == LOAD) begin
        load_ready = 1'b1;
        if (load_valid) begin
          ram_addr = 14'(waddr);
          ram_din  = load_data;
          ram_wren = 1'b1;
        end
      end else begin
        if (disp_req && !cpu_blocks_disp) begin
          disp_gnt = 1'b1;
          ram_addr = disp_addr;
        end else if (cpu_req) begin
          cpu_gnt  = 1'b1;
          ram_addr = cpu_addr;
          ram_wren = cpu_we;
          ram_din  = cpu_we ? cpu_wdata : 16'h0000;
        end
      end
    end
  end

  // Stage p1: sequencing state and read-valid tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      waddr       <= '0;
      starve      <= '0;
      disp_vld_p1 <= 1'b0;
      cpu_vld_p1  <= 1'b0;
    end else begin
      disp_vld_p1 <= disp_gnt;
      cpu_vld_p1  <= cpu_gnt && !cpu_we;

      if (state == LOAD) begin
        if (load_fire) begin
          waddr <= waddr + WADDR_W'(1);
          if (waddr == WADDR_W'(DEPTH - 1)) begin
            state <= RUN;
          end
        end
      end

      if (cpu_gnt || !cpu_req) begin
        starve <= '0;
      end else if (disp_gnt && (starve != STARVE_W'(CPU_STARVE))) begin
        starve <= starve + STARVE_W'(1);
      end
    end
  end

  // A reset cancels any read whose data would appear during the reset cycle.
  assign loaded      = (state == RUN) && !reset;
  assign disp_rvalid = disp_vld_p1 && !reset;
  assign cpu_rvalid  = cpu_vld_p1 && !reset;
  assign disp_rdata  = ram_dout;
  assign cpu_rdata   = ram_dout;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  localparam int DEPTH      = 4;
  localparam int CPU_STARVE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        loaded;
  logic        disp_req;
  logic [13:0] disp_addr;
  logic        disp_gnt;
  logic        disp_rvalid;
  logic [15:0] disp_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic [13:0] ram_addr;
  logic        ram_wren;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  int checks   = 0;
  int failures = 0;

  // Expected memory contents as the bench understands them.
  logic [15:0] exp_mem [0:16383];

  // SPRAM behaviour: synchronous write, registered read.
  logic [15:0] spram [0:16383];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) spram[ram_addr] <= ram_din;
    ram_dout <= spram[ram_addr];
  end

  vram_arbiter #(.DEPTH(DEPTH), .CPU_STARVE(CPU_STARVE)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready), .loaded(loaded),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0; load_data = 16'h0000;
    disp_req = 1'b0; disp_addr = 14'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 14'h0; cpu_wdata = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs();
    load_valid = 1'b1; load_data = 16'hFFFF; disp_req = 1'b1; cpu_req = 1'b1;
    tick(); tick();
    #4;
    checks++; if (loaded !== 1'b0) begin failures++; $display("FAIL reset_loaded got=%b exp=0", loaded); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL reset_load_ready got=%b exp=0", load_ready); end
    checks++; if ({disp_gnt, cpu_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b%b exp=00", disp_gnt, cpu_gnt); end
    checks++; if ({disp_rvalid, cpu_rvalid} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", disp_rvalid, cpu_rvalid); end
    checks++; if (ram_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", ram_wren); end
    tick();
  endtask

  task automatic test_load();
    reset = 1'b0; idle_inputs();
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1'b1; load_data = 16'hA000 + 16'(i);
      disp_req = 1'b1; cpu_req = 1'b1;
      #4;
      checks++; if (ram_wren !== 1'b1) begin failures++; $display("FAIL load_wren[%0d] got=%b exp=1", i, ram_wren); end
      checks++; if (ram_addr !== 14'(i)) begin failures++; $display("FAIL load_addr[%0d] got=%0d exp=%0d", i, ram_addr, i); end
      checks++; if (ram_din !== 16'hA000 + 16'(i)) begin failures++; $display("FAIL load_din[%0d] got=%h exp=%h", i, ram_din, 16'hA000 + 16'(i)); end
      checks++; if ({load_ready, loaded} !== 2'b10) begin failures++; $display("FAIL load_flags[%0d] got=%b%b exp=10", i, load_ready, loaded); end
      checks++; if ({disp_gnt, cpu_gnt} !== 2'b00) begin failures++; $display("FAIL load_gnt[%0d] got=%b%b exp=00", i, disp_gnt, cpu_gnt); end
      exp_mem[i] = 16'hA000 + 16'(i);
      tick();
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    #4;
    checks++; if (loaded !== 1'b1) begin failures++; $display("FAIL load_done got=%b exp=1", loaded); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL load_ready_after got=%b exp=0", load_ready); end
    checks++; if (ram_wren !== 1'b0) begin failures++; $display("FAIL load_extra_write got=%b exp=0", ram_wren); end
    tick();
    idle_inputs();
  endtask

  task automatic test_load_stall();
    int nw;
    int last_wr;
    bit done;
    nw = 0; last_wr = -10; done = 1'b0;
    reset = 1'b1; idle_inputs();
    tick();
    reset = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      load_valid = (cyc % 2 == 0);
      load_data = 16'hA000 + 16'(nw);
      disp_req = 1'b1; cpu_req = 1'b1; disp_addr = 14'h0; cpu_addr = 14'h0;
      #4;
      if (loaded === 1'b1) begin
        done = 1'b1;
        checks++; if (nw !== DEPTH) begin failures++; $display("FAIL stall_write_count got=%0d exp=%0d", nw, DEPTH); end
        checks++; if (cyc !== last_wr + 1) begin failures++; $display("FAIL stall_loaded_cycle got=%0d exp=%0d", cyc, last_wr + 1); end
      end else begin
        checks++; if ({disp_gnt, cpu_gnt} !== 2'b00) begin failures++; $display("FAIL stall_gnt[%0d] got=%b%b exp=00", cyc, disp_gnt, cpu_gnt); end
        checks++; if (ram_wren !== load_valid) begin failures++; $display("FAIL stall_wren[%0d] got=%b exp=%b", cyc, ram_wren, load_valid); end
        if (ram_wren === 1'b1) begin
          checks++; if (ram_addr !== 14'(nw)) begin failures++; $display("FAIL stall_addr[%0d] got=%0d exp=%0d", cyc, ram_addr, nw); end
          nw++; last_wr = cyc;
        end
      end
      tick();
    end
    checks++; if (!done) begin failures++; $display("FAIL stall_timeout got=loaded_low exp=loaded_high"); end
    idle_inputs();
    tick();
  endtask

  task automatic test_disp_read();
    disp_req = 1'b1; disp_addr = 14'h0002;
    #4;
    checks++; if (disp_gnt !== 1'b1) begin failures++; $display("FAIL dread_gnt got=%b exp=1", disp_gnt); end
    checks++; if (ram_addr !== 14'h0002 || ram_wren !== 1'b0) begin failures++; $display("FAIL dread_port got=%h/%b exp=0002/0", ram_addr, ram_wren); end
    tick();
    disp_req = 1'b0;
    #4;
    checks++; if (disp_rvalid !== 1'b1) begin failures++; $display("FAIL dread_rvalid got=%b exp=1", disp_rvalid); end
    checks++; if (disp_rdata !== exp_mem[2]) begin failures++; $display("FAIL dread_data got=%h exp=%h", disp_rdata, exp_mem[2]); end
    tick();
  endtask

  task automatic test_starve();
    int wins;
    bit exp_c;
    bit prev_c;
    wins = 0; prev_c = 1'b0;
    disp_req = 1'b1; disp_addr = 14'h0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0001;
    for (int n = 0; n < 9; n++) begin
      #4;
      exp_c = (wins == CPU_STARVE);
      checks++; if (disp_gnt !== !exp_c || cpu_gnt !== exp_c) begin failures++; $display("FAIL starve_pattern[%0d] got=d%b c%b exp=d%b c%b", n, disp_gnt, cpu_gnt, !exp_c, exp_c); end
      checks++; if (cpu_rvalid !== prev_c) begin failures++; $display("FAIL starve_rvalid[%0d] got=%b exp=%b", n, cpu_rvalid, prev_c); end
      if (prev_c) begin
        checks++; if (cpu_rdata !== exp_mem[1]) begin failures++; $display("FAIL starve_rdata[%0d] got=%h exp=%h", n, cpu_rdata, exp_mem[1]); end
      end
      wins = exp_c ? 0 : wins + 1;
      prev_c = exp_c;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0003; cpu_wdata = 16'h1234;
    #4;
    checks++; if (cpu_gnt !== 1'b1 || ram_wren !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b/%b exp=1/1", cpu_gnt, ram_wren); end
    checks++; if (ram_addr !== 14'h0003 || ram_din !== 16'h1234) begin failures++; $display("FAIL wr_port got=%h/%h exp=0003/1234", ram_addr, ram_din); end
    exp_mem[3] = 16'h1234;
    tick();
    idle_inputs();
    disp_req = 1'b1; disp_addr = 14'h0003;
    #4;
    checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=0", cpu_rvalid); end
    checks++; if (disp_gnt !== 1'b1) begin failures++; $display("FAIL wr_dgnt got=%b exp=1", disp_gnt); end
    tick();
    disp_req = 1'b0;
    #4;
    checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== exp_mem[3]) begin failures++; $display("FAIL wr_readback got=%b/%h exp=1/%h", disp_rvalid, disp_rdata, exp_mem[3]); end
    tick();
  endtask

  task automatic test_random();
    bit dp, cp, cwe, exp_d, exp_c, pd, pc;
    logic [13:0] da, ca;
    logic [15:0] cwd, pdd, pcd;
    int wins, cwait, maxw;
    dp = 0; cp = 0; cwe = 0; pd = 0; pc = 0; wins = 0; cwait = 0; maxw = 0;
    da = 0; ca = 0; cwd = 0; pdd = 0; pcd = 0;
    for (int n = 0; n < 300; n++) begin
      if (!dp) begin dp = ($urandom_range(0, 2) != 0); da = 14'($urandom_range(0, 3)); end
      if (!cp) begin cp = ($urandom_range(0, 1) == 1); cwe = ($urandom_range(0, 1) == 1); ca = 14'($urandom_range(0, 3)); cwd = 16'($urandom); end
      disp_req = dp; disp_addr = da;
      cpu_req = cp; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
      #4;
      exp_d = dp && !(cp && wins >= CPU_STARVE);
      exp_c = !exp_d && cp;
      checks++; if (disp_gnt !== exp_d || cpu_gnt !== exp_c) begin failures++; $display("FAIL rnd_gnt[%0d] got=d%b c%b exp=d%b c%b", n, disp_gnt, cpu_gnt, exp_d, exp_c); end
      checks++; if (disp_rvalid !== pd || cpu_rvalid !== pc) begin failures++; $display("FAIL rnd_rvalid[%0d] got=d%b c%b exp=d%b c%b", n, disp_rvalid, cpu_rvalid, pd, pc); end
      if (pd) begin checks++; if (disp_rdata !== pdd) begin failures++; $display("FAIL rnd_drdata[%0d] got=%h exp=%h", n, disp_rdata, pdd); end end
      if (pc) begin checks++; if (cpu_rdata !== pcd) begin failures++; $display("FAIL rnd_crdata[%0d] got=%h exp=%h", n, cpu_rdata, pcd); end end
      if (exp_d) begin
        pdd = exp_mem[da];
        checks++; if (ram_addr !== da || ram_wren !== 1'b0) begin failures++; $display("FAIL rnd_dport[%0d] got=%h/%b exp=%h/0", n, ram_addr, ram_wren, da); end
      end
      if (exp_c) begin
        checks++; if (ram_addr !== ca || ram_wren !== cwe) begin failures++; $display("FAIL rnd_cport[%0d] got=%h/%b exp=%h/%b", n, ram_addr, ram_wren, ca, cwe); end
        if (cwe) exp_mem[ca] = cwd;
        else pcd = exp_mem[ca];
      end
      pd = exp_d;
      pc = exp_c && !cwe;
      if (exp_c || !cp) wins = 0;
      else if (exp_d && wins < CPU_STARVE) wins++;
      if (cp) cwait++;
      if (cpu_gnt === 1'b1) begin
        if (cwait > maxw) maxw = cwait;
        cwait = 0;
      end
      if (exp_d) dp = 0;
      if (exp_c) cp = 0;
      tick();
    end
    checks++; if (maxw > CPU_STARVE + 1) begin failures++; $display("FAIL rnd_cpu_wait got=%0d exp<=%0d", maxw, CPU_STARVE + 1); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_midrun();
    disp_req = 1'b1; disp_addr = 14'h0001;
    #4;
    checks++; if (disp_gnt !== 1'b1) begin failures++; $display("FAIL mid_gnt got=%b exp=1", disp_gnt); end
    tick();
    reset = 1'b1; disp_req = 1'b0; load_valid = 1'b1; load_data = 16'hB000;
    #4;
    checks++; if (disp_rvalid !== 1'b0) begin failures++; $display("FAIL mid_rvalid got=%b exp=0", disp_rvalid); end
    checks++; if (loaded !== 1'b0 || ram_wren !== 1'b0 || load_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_outs got=%b%b%b exp=000", loaded, ram_wren, load_ready); end
    tick();
    reset = 1'b0;
    #4;
    checks++; if (loaded !== 1'b0 || load_ready !== 1'b1) begin failures++; $display("FAIL mid_reload_flags got=%b%b exp=01", loaded, load_ready); end
    checks++; if (ram_wren !== 1'b1 || ram_addr !== 14'h0000) begin failures++; $display("FAIL mid_reload_addr got=%b/%h exp=1/0000", ram_wren, ram_addr); end
    tick();
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_load();
    test_load_stall();
    test_disp_read();
    test_starve();
    test_write_read();
    test_random();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Sequencer and arbiter for the single-port 16K×16 SPRAM holding screen memory. After reset it streams the initial image from the SPI flash ROM reader into SPRAM. It then shares the one SPRAM port, one access per cycle, between the display scan-out reader (priority) and the CPU screen port (guaranteed a slot within a bounded number of cycles). It sits between ROM, CPU memory map, display controller and the SB_SPRAM256KA instance.

## Interface
- DEPTH, 16384: words loaded from ROM before run phase; 1 ≤ DEPTH ≤ 16384
- CPU_STARVE, 2: max consecutive cycles the display may win while CPU is pending; ≥ 1

- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- load_valid  in  1  ROM word available
- load_data  in  16  ROM word
- load_ready  out  1  arbiter accepts ROM word this cycle
- loaded  out  1  load phase complete
- disp_req  in  1  display read request; held with disp_addr stable until granted
- disp_addr  in  14  display read address
- disp_gnt  out  1  display access performed this cycle
- disp_rvalid  out  1  disp_rdata valid
- disp_rdata  out  16  display read data
- cpu_req  in  1  CPU request; cpu_we/addr/wdata held stable until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  14  CPU address
- cpu_wdata  in  16  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_rvalid  out  1  cpu_rdata valid (reads only)
- cpu_rdata  out  16  CPU read data
- ram_addr  out  14  to SPRAM ADDRESS
- ram_wren  out  1  to SPRAM WREN
- ram_din  out  16  to SPRAM DATAIN
- ram_dout  in  16  from SPRAM DATAOUT (registered; valid cycle after address)

## Operation
- States: LOAD, RUN. Reset → LOAD.
- LOAD: load_ready = !reset. On load_valid && load_ready: ram_addr = waddr, ram_din = load_data, ram_wren = 1, waddr++. The write of waddr = DEPTH−1 moves to RUN next cycle. loaded = (state == RUN). In LOAD, disp_gnt = cpu_gnt = 0 regardless of requests.
- RUN: load_ready = 0. waddr is frozen. Each cycle at most one grant:
  - If disp_req && !(cpu_req && starve == CPU_STARVE): grant display.
  - Else if cpu_req: grant CPU.
  - Else: idle, with ram_wren = 0 and ram_addr = disp_addr (don't-care).
- starve counter, clog2(CPU_STARVE+1) bits:
  - Increments when display is granted while cpu_req is high.
  - Clears when CPU is granted or cpu_req is low.
  - Saturates at CPU_STARVE.
- Display grant: ram_addr = disp_addr, ram_wren = 0.
- CPU grant: ram_addr = cpu_addr. ram_wren = cpu_we. ram_din = cpu_wdata when cpu_we, else 0.
- disp_rvalid / cpu_rvalid are registered copies of (disp_gnt) / (cpu_gnt && !cpu_we). rdata outputs pass through ram_dout and are meaningful only while rvalid is high.
- Grants are combinational from requests and registered state. A requester deasserts or changes its request the cycle after its grant.
- waddr width: clog2(DEPTH)+1 bits. ram_addr takes its low 14 bits.

## Timing
- Reset values: loaded 0, load_ready 0 (while reset high), disp_gnt 0, cpu_gnt 0, disp_rvalid 0, cpu_rvalid 0, ram_wren 0, waddr 0, starve 0.
- Reset mid-LOAD or mid-RUN: next cycle is LOAD with waddr = 0. Any read in flight loses its rvalid. No ram_wren during the reset cycle.
- Read latency: grant in cycle N → rvalid and data in cycle N+1.
- Write: takes effect in its grant cycle. A read of the same address granted in N+1 returns the new data.
- Back-to-back reads: one per cycle, full throughput.
- Load: one word per cycle max. 16384 cycles minimum at DEPTH = 16384. load_valid stalls are tolerated indefinitely.
- Bounded CPU wait: a held cpu_req is granted within CPU_STARVE+1 cycles in RUN.
- Simultaneous requests with starve < CPU_STARVE: display wins.

## Test plan
- **Load:** DEPTH = 4, load_valid held high with data 0xA000..0xA003. Required: ram_wren high on 4 consecutive cycles at addresses 0..3; loaded rises on the 5th cycle; load_ready low afterwards.
- **Load stall:** same setup with load_valid toggling every cycle. Required: exactly 4 writes; loaded rises the cycle after the last write; no gnt asserted while loaded = 0 even with disp_req and cpu_req high.
- **Display read:** in RUN, display reads 0x0002. Required: disp_gnt in the request cycle; disp_rvalid one cycle later with disp_rdata = 0xA002.
- **Starvation bound:** disp_req and cpu_req (read 0x0001) held continuously, CPU_STARVE = 2. Required: grant pattern D, D, C, D, D, C…; cpu_rvalid returns 0xA001.
- **Write then read:** CPU writes 0x1234 to 0x0003 in cycle N; display reads 0x0003 in N+1. Required: disp_rdata = 0x1234 in N+2.
- **Reset mid-run:** reset asserted in the cycle after a display grant. Required: disp_rvalid 0; loaded 0; LOAD restarts at address 0.
